axilite_mem_slave_p: RTL and testbench
======================================

Name: axilite_mem_slave_p

Overview:
Parametrised AXI4-Lite memory slave; the next generation of the team's single-beat AXI-lite memory.
- Adds configurable data width, address width and depth.
- Adds byte-lane strobes, full VALID/READY backpressure on the B and R channels, and independent AW/W acceptance.
- Adds a one-cycle write-notification port for downstream mirror and monitor logic.
- Sits between the interconnect and the core's data-memory consumers.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, minimum 32.
- ADDR_W, 12, AXI byte-address width.
- DEPTH, 256, number of DATA_W words; power of 2, DEPTH*DATA_W/8 <= 2^ADDR_W.

Ports:
- AXI_ACLK  in  1  clock
- AXI_ARESET  in  1  reset
- AXI_AWADDR  in  ADDR_W  write byte address
- AXI_AWVALID  in  1 / AXI_AWREADY  out  1
- AXI_WDATA  in  DATA_W / AXI_WSTRB  in  DATA_W/8
- AXI_WVALID  in  1 / AXI_WREADY  out  1
- AXI_BRESP  out  2 / AXI_BVALID  out  1 / AXI_BREADY  in  1
- AXI_ARADDR  in  ADDR_W / AXI_ARVALID  in  1 / AXI_ARREADY  out  1
- AXI_RDATA  out  DATA_W / AXI_RRESP  out  2 / AXI_RVALID  out  1 / AXI_RREADY  in  1
- axi_mem_w  out  1  write-commit pulse
- axi_mem_addr  out  ADDR_W  committed byte address
- axi_mem_data  out  DATA_W  committed write data
- axi_mem_strb  out  DATA_W/8  committed strobes

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high (AXI_ACLK, AXI_ARESET).
  - On the reset edge all outputs go to 0, both FSMs return to IDLE, and latched AW/W state is discarded.
  - Memory contents are not cleared.
  - Reset wins over any handshake on the same edge, including in W_RESP/R_DATA.
- Addressing: word index = ADDR[ADDR_W-1:log2(DATA_W/8)]; low bits ignored. An index >= DEPTH is out of range.
- Write FSM, W_IDLE:
  - AWREADY = !aw_held and WREADY = !w_held (registered). AW and W are captured independently in any order or in the same cycle; each is held until its partner arrives.
  - When both are held, or both handshake together, the next edge does three things:
    - commits bytes where WSTRB=1; lanes with WSTRB=0 are unchanged;
    - pulses axi_mem_w=1 for one cycle with axi_mem_addr/data/strb;
    - sets BVALID=1 and enters W_RESP.
  - Latency: last of AW/W handshake at edge N gives BVALID and memory update visible at N+1.
- Write FSM, W_RESP:
  - AWREADY = WREADY = 0.
  - BVALID and BRESP are held stable until BREADY; the BVALID&&BREADY edge returns to W_IDLE with ready re-asserted next cycle.
  - Maximum throughput is one write per 2 cycles.
- Read FSM:
  - R_IDLE: ARREADY=1. An AR handshake at edge N latches data and enters R_DATA with RVALID=1 at N+1.
  - R_DATA: ARREADY=0; RDATA/RRESP are held stable until RREADY. The RVALID&&RREADY edge returns to R_IDLE.
  - RDATA = 0 whenever RVALID=0.
- Read/write collision: read and commit on the same edge at the same index returns the old data. A read handshake after the commit edge returns the new data.
- Out-of-range access: behaviour is set by ERR_RESP_EN.
- axi_mem_w never pulses for a write that did not modify memory.
- BRESP/RRESP = 2'b00 (OKAY) unless an error is defined below.
- Read and write paths are fully concurrent.

Optional Feature:
Macro AXILITE_MEM_ERR_RESP_EN.
- Defined:
  - an out-of-range write leaves memory untouched, suppresses axi_mem_w and returns BRESP=2'b10 (SLVERR);
  - an out-of-range read returns RDATA=0, RRESP=2'b10;
  - timing is identical to the in-range case.
- Undefined: the index wraps modulo DEPTH and the response is always OKAY.

Test Plan:
- Reset, then write AW=0x010 + W=0xDEADBEEF with WSTRB=4'hF in the same cycle, BREADY=1:
  - BVALID at +1, BRESP=0;
  - axi_mem_w pulses once with addr 0x010;
  - read 0x010 gives RDATA=0xDEADBEEF at ARhandshake+1.
- W=0x11223344 sent 3 cycles before AW=0x020, then partial write WSTRB=4'b0101 data 0xAABBCCDD to 0x020:
  - first write commits only after AW; WREADY stays 0 while W is held;
  - readback = 0x11BB33DD.
- BREADY and RREADY held low 5 cycles:
  - BVALID/BRESP and RVALID/RDATA stay stable;
  - AWREADY/WREADY/ARREADY stay 0;
  - READY pulse completes and each FSM returns to IDLE.
- AR and AW/W commit to 0x030 on the same edge (old value 0x1, new value 0x2):
  - read returns 0x1;
  - next read returns 0x2.
- Access 0x400 (index 256, DEPTH=256):
  - with AXILITE_MEM_ERR_RESP_EN: BRESP=2'b10, RRESP=2'b10, RDATA=0, no axi_mem_w, word 0 unchanged;
  - without it: writes word 0, OKAY.
- Assert AXI_ARESET in W_RESP and R_DATA:
  - next edge gives all outputs 0;
  - previously written data is still readable after reset.

Source files
------------

// File: rtl/axilite_mem_slave_p.sv
// ---------------------------------------------------------------------------
// axilite_mem_slave_p
//
// Parametrised AXI4-Lite memory slave. A DEPTH x DATA_W word array that is
// written through the AW/W/B channels and read through the AR/R channels.
// The write and read paths run concurrently and independently.
//
// Parameters:
//   DATA_W  data width in bits (multiple of 8, minimum 32)
//   ADDR_W  AXI byte-address width
//   DEPTH   number of DATA_W words (power of 2, DEPTH*DATA_W/8 <= 2^ADDR_W)
//
// Ports:
//   AXI_ACLK, AXI_ARESET       clock, synchronous active-high reset
//   AXI_AW*                    write address channel
//   AXI_W*                     write data channel, byte strobes in AXI_WSTRB
//   AXI_B*                     write response channel
//   AXI_AR*                    read address channel
//   AXI_R*                     read data channel
//   axi_mem_w                  one-cycle pulse when a write changed memory
//   axi_mem_addr/data/strb     byte address, data and strobes of that write
//
// Build option:
//   AXILITE_MEM_ERR_RESP_EN    when defined, accesses whose word index is
//                              >= DEPTH are rejected with SLVERR (reads
//                              return 0, writes leave memory untouched).
//                              When undefined, the index wraps modulo DEPTH
//                              and every response is OKAY.
//
// Memory contents are not cleared by reset.
// ---------------------------------------------------------------------------
module axilite_mem_slave_p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 256
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESET,
  input  logic [ADDR_W-1:0]     AXI_AWADDR,
  input  logic                  AXI_AWVALID,
  output logic                  AXI_AWREADY,
  input  logic [DATA_W-1:0]     AXI_WDATA,
  input  logic [DATA_W/8-1:0]   AXI_WSTRB,
  input  logic                  AXI_WVALID,
  output logic                  AXI_WREADY,
  output logic [1:0]            AXI_BRESP,
  output logic                  AXI_BVALID,
  input  logic                  AXI_BREADY,
  input  logic [ADDR_W-1:0]     AXI_ARADDR,
  input  logic                  AXI_ARVALID,
  output logic                  AXI_ARREADY,
  output logic [DATA_W-1:0]     AXI_RDATA,
  output logic [1:0]            AXI_RRESP,
  output logic                  AXI_RVALID,
  input  logic                  AXI_RREADY,
  output logic                  axi_mem_w,
  output logic [ADDR_W-1:0]     axi_mem_addr,
  output logic [DATA_W-1:0]     axi_mem_data,
  output logic [DATA_W/8-1:0]   axi_mem_strb
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int LSB       = $clog2(STRB_W);
  localparam int IDX_W     = ADDR_W - LSB;
  localparam int MEM_IDX_W = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write-side state
  logic [0:0]        w_state;
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              aw_ready_q;
  logic              w_ready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              mem_w_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [STRB_W-1:0] mem_strb_q;

  // Read-side state
  logic [0:0]        r_state;
  logic              ar_ready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;

  // Write commit decode
  logic                 aw_hs;
  logic                 w_hs;
  logic                 aw_have;
  logic                 w_have;
  logic                 commit;
  logic [ADDR_W-1:0]    cmt_addr;
  logic [DATA_W-1:0]    cmt_data;
  logic [STRB_W-1:0]    cmt_strb;
  logic [IDX_W-1:0]     cmt_idx_full;
  logic [MEM_IDX_W-1:0] cmt_idx;
  logic                 cmt_in_range;
  logic                 cmt_err;
  logic                 cmt_we;

  // Read decode
  logic                 ar_hs;
  logic [IDX_W-1:0]     ar_idx_full;
  logic [MEM_IDX_W-1:0] ar_idx;
  logic                 ar_in_range;
  logic                 ar_err;

  // A write commits when both halves are available: either already held
  // from an earlier cycle or handshaking right now. The held copy takes
  // priority because the channel's ready is low while it is held.
  always_comb begin
    aw_hs        = AXI_AWVALID && aw_ready_q;
    w_hs         = AXI_WVALID && w_ready_q;
    aw_have      = aw_held || aw_hs;
    w_have       = w_held || w_hs;
    commit       = (w_state == W_IDLE) && aw_have && w_have;
    cmt_addr     = aw_held ? aw_addr_q : AXI_AWADDR;
    cmt_data     = w_held ? w_data_q : AXI_WDATA;
    cmt_strb     = w_held ? w_strb_q : AXI_WSTRB;
    cmt_idx_full = cmt_addr[ADDR_W-1:LSB];
    cmt_idx      = cmt_idx_full[MEM_IDX_W-1:0];
    cmt_in_range = (cmt_idx_full >> MEM_IDX_W) == '0;
`ifdef AXILITE_MEM_ERR_RESP_EN
    cmt_err      = !cmt_in_range;
`else
    cmt_err      = 1'b0;
`endif
    cmt_we       = commit && !cmt_err;
  end

  // Read address decode; the low byte-offset bits never select anything.
  always_comb begin
    ar_hs       = AXI_ARVALID && ar_ready_q;
    ar_idx_full = AXI_ARADDR[ADDR_W-1:LSB];
    ar_idx      = ar_idx_full[MEM_IDX_W-1:0];
    ar_in_range = (ar_idx_full >> MEM_IDX_W) == '0;
`ifdef AXILITE_MEM_ERR_RESP_EN
    ar_err      = !ar_in_range;
`else
    ar_err      = 1'b0;
`endif
  end

`ifdef AXILITE_MEM_ERR_RESP_EN
  logic unused_bits;
  assign unused_bits = ^AXI_ARADDR[LSB-1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{AXI_ARADDR[LSB-1:0], ar_in_range, cmt_in_range};
`endif

  // Memory array: byte-lane writes on commit. Reset suppresses a commit on
  // the same edge but never clears stored data.
  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESET && cmt_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (cmt_strb[b]) begin
          mem[cmt_idx][b*8 +: 8] <= cmt_data[b*8 +: 8];
        end
      end
    end
  end

  // Write FSM. In W_IDLE each of AW and W is captured independently and
  // its ready drops while it waits for its partner. Once both are present
  // the write commits, the notification port pulses (only if some byte was
  // actually written) and the response is held in W_RESP until BREADY.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      w_state    <= W_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      mem_w_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_strb_q <= '0;
    end else begin
      mem_w_q <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= cmt_err ? RESP_SLVERR : RESP_OKAY;
            w_state    <= W_RESP;
            if (cmt_we && (cmt_strb != '0)) begin
              mem_w_q    <= 1'b1;
              mem_addr_q <= cmt_addr;
              mem_data_q <= cmt_data;
              mem_strb_q <= cmt_strb;
            end
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              aw_addr_q <= AXI_AWADDR;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= AXI_WDATA;
              w_strb_q <= AXI_WSTRB;
            end
            aw_ready_q <= !aw_have;
            w_ready_q  <= !w_have;
          end
        end
        W_RESP: begin
          if (AXI_BREADY) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM. The array is sampled on the AR handshake edge, so a commit on
  // that same edge is not yet visible and the old word is returned. RDATA is
  // forced to zero whenever no response is pending.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_state    <= R_IDLE;
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state    <= R_DATA;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= ar_err ? '0 : mem[ar_idx];
            rresp_q    <= ar_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (AXI_RREADY) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign AXI_AWREADY  = aw_ready_q;
  assign AXI_WREADY   = w_ready_q;
  assign AXI_BVALID   = bvalid_q;
  assign AXI_BRESP    = bresp_q;
  assign AXI_ARREADY  = ar_ready_q;
  assign AXI_RVALID   = rvalid_q;
  assign AXI_RDATA    = rdata_q;
  assign AXI_RRESP    = rresp_q;
  assign axi_mem_w    = mem_w_q;
  assign axi_mem_addr = mem_addr_q;
  assign axi_mem_data = mem_data_q;
  assign axi_mem_strb = mem_strb_q;

endmodule

// File: tb/tb_axilite_mem_slave_p.sv
// ---------------------------------------------------------------------------
// tb_axilite_mem_slave_p
//
// Self-checking bench for axilite_mem_slave_p (default parameters). Inputs
// are driven and outputs sampled on the falling clock edge. Expected values
// come from a word-array reference model updated with the byte-strobe and
// addressing rules; AXILITE_MEM_ERR_RESP_EN selects the model's
// out-of-range behaviour.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axilite_mem_slave_p;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 256;
  localparam int STRB_W = DATA_W / 8;

`ifdef AXILITE_MEM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                AXI_ACLK = 1'b0;
  logic                AXI_ARESET;
  logic [ADDR_W-1:0]   AXI_AWADDR;
  logic                AXI_AWVALID;
  logic                AXI_AWREADY;
  logic [DATA_W-1:0]   AXI_WDATA;
  logic [STRB_W-1:0]   AXI_WSTRB;
  logic                AXI_WVALID;
  logic                AXI_WREADY;
  logic [1:0]          AXI_BRESP;
  logic                AXI_BVALID;
  logic                AXI_BREADY;
  logic [ADDR_W-1:0]   AXI_ARADDR;
  logic                AXI_ARVALID;
  logic                AXI_ARREADY;
  logic [DATA_W-1:0]   AXI_RDATA;
  logic [1:0]          AXI_RRESP;
  logic                AXI_RVALID;
  logic                AXI_RREADY;
  logic                axi_mem_w;
  logic [ADDR_W-1:0]   axi_mem_addr;
  logic [DATA_W-1:0]   axi_mem_data;
  logic [STRB_W-1:0]   axi_mem_strb;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];

  always #5 AXI_ACLK = ~AXI_ACLK;

  axilite_mem_slave_p #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .AXI_ACLK    (AXI_ACLK),
    .AXI_ARESET  (AXI_ARESET),
    .AXI_AWADDR  (AXI_AWADDR),
    .AXI_AWVALID (AXI_AWVALID),
    .AXI_AWREADY (AXI_AWREADY),
    .AXI_WDATA   (AXI_WDATA),
    .AXI_WSTRB   (AXI_WSTRB),
    .AXI_WVALID  (AXI_WVALID),
    .AXI_WREADY  (AXI_WREADY),
    .AXI_BRESP   (AXI_BRESP),
    .AXI_BVALID  (AXI_BVALID),
    .AXI_BREADY  (AXI_BREADY),
    .AXI_ARADDR  (AXI_ARADDR),
    .AXI_ARVALID (AXI_ARVALID),
    .AXI_ARREADY (AXI_ARREADY),
    .AXI_RDATA   (AXI_RDATA),
    .AXI_RRESP   (AXI_RRESP),
    .AXI_RVALID  (AXI_RVALID),
    .AXI_RREADY  (AXI_RREADY),
    .axi_mem_w   (axi_mem_w),
    .axi_mem_addr(axi_mem_addr),
    .axi_mem_data(axi_mem_data),
    .axi_mem_strb(axi_mem_strb)
  );

  // Counts every comparison and reports the ones that disagree.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: word index is the byte address divided by the word size.
  function automatic bit modelOutOfRange(input logic [ADDR_W-1:0] a);
    return ((int'(a) / STRB_W) >= DEPTH) && ERR_EN;
  endfunction

  function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] a);
    logic [7:0] widx;
    widx = 8'((int'(a) / STRB_W) % DEPTH);
    if (modelOutOfRange(a)) return '0;
    return model_mem[widx];
  endfunction

  function automatic logic [1:0] modelResp(input logic [ADDR_W-1:0] a);
    return modelOutOfRange(a) ? 2'b10 : 2'b00;
  endfunction

  // Applies a write to the model; returns whether any byte was written.
  function automatic bit modelWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                    input logic [STRB_W-1:0] s);
    logic [7:0] widx;
    widx = 8'((int'(a) / STRB_W) % DEPTH);
    if (modelOutOfRange(a)) return 1'b0;
    for (int b = 0; b < STRB_W; b++) begin
      if (s[b]) model_mem[widx][b*8 +: 8] = d[b*8 +: 8];
    end
    return s != 4'd0;
  endfunction

  task automatic stepCycle;
    @(posedge AXI_ACLK);
    @(negedge AXI_ACLK);
  endtask

  // One complete write: AW and W presented after their own delays, then
  // the response held off for b_delay cycles. Entered and left at negedge.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                               input logic [STRB_W-1:0] strb, input int aw_delay,
                               input int w_delay, input int b_delay, input bit chk);
    bit aw_done;
    bit w_done;
    bit aw_hs;
    bit w_hs;
    bit exp_pulse;
    logic [1:0] exp_resp;
    int cyc;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    exp_resp = modelResp(addr);
    while (!(aw_done && w_done) && cyc < 64) begin
      AXI_AWADDR  = addr;
      AXI_AWVALID = !aw_done && (cyc >= aw_delay);
      AXI_WDATA   = data;
      AXI_WSTRB   = strb;
      AXI_WVALID  = !w_done && (cyc >= w_delay);
      aw_hs = AXI_AWVALID && AXI_AWREADY;
      w_hs  = AXI_WVALID && AXI_WREADY;
      stepCycle();
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      cyc++;
      if (chk && !(aw_done && w_done)) begin
        checkOutput("bvalid_early", 64'(AXI_BVALID), 64'(0));
        if (w_done)  checkOutput("wready_held", 64'(AXI_WREADY), 64'(0));
        if (aw_done) checkOutput("awready_held", 64'(AXI_AWREADY), 64'(0));
      end
    end
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      checkOutput("write_timeout", 64'(0), 64'(1));
      return;
    end
    exp_pulse = modelWrite(addr, data, strb);
    if (chk) begin
      checkOutput("bvalid", 64'(AXI_BVALID), 64'(1));
      checkOutput("bresp", 64'(AXI_BRESP), 64'(exp_resp));
      checkOutput("awready_resp", 64'(AXI_AWREADY), 64'(0));
      checkOutput("wready_resp", 64'(AXI_WREADY), 64'(0));
      checkOutput("mem_w", 64'(axi_mem_w), 64'(exp_pulse));
      if (exp_pulse) begin
        checkOutput("mem_addr", 64'(axi_mem_addr), 64'(addr));
        checkOutput("mem_data", 64'(axi_mem_data), 64'(data));
        checkOutput("mem_strb", 64'(axi_mem_strb), 64'(strb));
      end
    end
    for (int i = 0; i < b_delay; i++) begin
      stepCycle();
      if (chk) begin
        checkOutput("bvalid_stall", 64'(AXI_BVALID), 64'(1));
        checkOutput("bresp_stall", 64'(AXI_BRESP), 64'(exp_resp));
        checkOutput("awready_stall", 64'(AXI_AWREADY), 64'(0));
        checkOutput("wready_stall", 64'(AXI_WREADY), 64'(0));
        checkOutput("mem_w_once", 64'(axi_mem_w), 64'(0));
      end
    end
    AXI_BREADY = 1'b1;
    stepCycle();
    AXI_BREADY = 1'b0;
    if (chk) begin
      checkOutput("bvalid_done", 64'(AXI_BVALID), 64'(0));
      checkOutput("awready_back", 64'(AXI_AWREADY), 64'(1));
      checkOutput("wready_back", 64'(AXI_WREADY), 64'(1));
      checkOutput("mem_w_end", 64'(axi_mem_w), 64'(0));
    end
  endtask

  // One complete read: AR after ar_delay cycles, RREADY after r_delay.
  task automatic applyRead(input logic [ADDR_W-1:0] addr, input int ar_delay, input int r_delay,
                           output logic [DATA_W-1:0] got);
    bit done;
    bit hs;
    int cyc;
    logic [DATA_W-1:0] exp_data;
    logic [1:0] exp_resp;
    done     = 1'b0;
    cyc      = 0;
    exp_data = '0;
    exp_resp = 2'b00;
    got      = '0;
    while (!done && cyc < 64) begin
      AXI_ARADDR  = addr;
      AXI_ARVALID = cyc >= ar_delay;
      hs = AXI_ARVALID && AXI_ARREADY;
      if (hs) begin
        exp_data = modelRead(addr);
        exp_resp = modelResp(addr);
      end
      stepCycle();
      done = hs;
      cyc++;
      if (!done) checkOutput("rvalid_early", 64'(AXI_RVALID), 64'(0));
    end
    AXI_ARVALID = 1'b0;
    if (!done) begin
      checkOutput("read_timeout", 64'(0), 64'(1));
      return;
    end
    got = AXI_RDATA;
    checkOutput("rvalid", 64'(AXI_RVALID), 64'(1));
    checkOutput("rdata", 64'(AXI_RDATA), 64'(exp_data));
    checkOutput("rresp", 64'(AXI_RRESP), 64'(exp_resp));
    checkOutput("arready_busy", 64'(AXI_ARREADY), 64'(0));
    for (int i = 0; i < r_delay; i++) begin
      stepCycle();
      checkOutput("rvalid_stall", 64'(AXI_RVALID), 64'(1));
      checkOutput("rdata_stall", 64'(AXI_RDATA), 64'(exp_data));
      checkOutput("arready_stall", 64'(AXI_ARREADY), 64'(0));
    end
    AXI_RREADY = 1'b1;
    stepCycle();
    AXI_RREADY = 1'b0;
    checkOutput("rvalid_done", 64'(AXI_RVALID), 64'(0));
    checkOutput("rdata_idle", 64'(AXI_RDATA), 64'(0));
    checkOutput("arready_back", 64'(AXI_ARREADY), 64'(1));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_awready"}, 64'(AXI_AWREADY), 64'(0));
    checkOutput({tag, "_wready"}, 64'(AXI_WREADY), 64'(0));
    checkOutput({tag, "_arready"}, 64'(AXI_ARREADY), 64'(0));
    checkOutput({tag, "_bvalid"}, 64'(AXI_BVALID), 64'(0));
    checkOutput({tag, "_bresp"}, 64'(AXI_BRESP), 64'(0));
    checkOutput({tag, "_rvalid"}, 64'(AXI_RVALID), 64'(0));
    checkOutput({tag, "_rdata"}, 64'(AXI_RDATA), 64'(0));
    checkOutput({tag, "_rresp"}, 64'(AXI_RRESP), 64'(0));
    checkOutput({tag, "_mem_w"}, 64'(axi_mem_w), 64'(0));
    checkOutput({tag, "_mem_addr"}, 64'(axi_mem_addr), 64'(0));
    checkOutput({tag, "_mem_data"}, 64'(axi_mem_data), 64'(0));
    checkOutput({tag, "_mem_strb"}, 64'(axi_mem_strb), 64'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] word0;
    logic [DATA_W-1:0] old_val;
    logic [DATA_W-1:0] rst_data;
    logic [ADDR_W-1:0] addr;
    bit pulse;

    AXI_ARESET  = 1'b1;
    AXI_AWADDR  = '0;
    AXI_AWVALID = 1'b0;
    AXI_WDATA   = '0;
    AXI_WSTRB   = '0;
    AXI_WVALID  = 1'b0;
    AXI_BREADY  = 1'b0;
    AXI_ARADDR  = '0;
    AXI_ARVALID = 1'b0;
    AXI_RREADY  = 1'b0;
    repeat (3) stepCycle();
    checkAllZero("reset");
    AXI_ARESET = 1'b0;
    stepCycle();

    // Fill every word so the model knows the whole array.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(12'(i * STRB_W), $urandom, 4'hF, 0, 0, 0, 1'b0);
    end

    // Same-cycle AW/W, full strobes, immediate readback.
    applyStimulus(12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b1);
    applyRead(12'h010, 0, 0, got);
    checkOutput("tp_deadbeef", 64'(got), 64'(32'hDEADBEEF));

    // W three cycles ahead of AW, then a partial-strobe write.
    applyStimulus(12'h020, 32'h11223344, 4'hF, 3, 0, 0, 1'b1);
    applyStimulus(12'h020, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 1'b1);
    applyRead(12'h020, 0, 0, got);
    checkOutput("tp_partial", 64'(got), 64'(32'h11BB33DD));

    // AW ahead of W, and B/R backpressure for five cycles.
    applyStimulus(12'h024, 32'h0BADF00D, 4'hF, 0, 2, 5, 1'b1);
    applyRead(12'h024, 0, 5, got);

    // Read and commit to the same word on the same edge.
    applyStimulus(12'h030, 32'h1, 4'hF, 0, 0, 0, 1'b1);
    checkOutput("coll_ready", 64'({AXI_AWREADY, AXI_WREADY, AXI_ARREADY}), 64'(3'b111));
    old_val = modelRead(12'h030);
    AXI_AWADDR = 12'h030; AXI_AWVALID = 1'b1;
    AXI_WDATA = 32'h2; AXI_WSTRB = 4'hF; AXI_WVALID = 1'b1;
    AXI_ARADDR = 12'h030; AXI_ARVALID = 1'b1;
    stepCycle();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; AXI_ARVALID = 1'b0;
    pulse = modelWrite(12'h030, 32'h2, 4'hF);
    checkOutput("coll_rvalid", 64'(AXI_RVALID), 64'(1));
    checkOutput("coll_old", 64'(AXI_RDATA), 64'(old_val));
    checkOutput("coll_old_const", 64'(AXI_RDATA), 64'(32'h1));
    checkOutput("coll_bvalid", 64'(AXI_BVALID), 64'(1));
    checkOutput("coll_mem_w", 64'(axi_mem_w), 64'(pulse));
    AXI_BREADY = 1'b1; AXI_RREADY = 1'b1;
    stepCycle();
    AXI_BREADY = 1'b0; AXI_RREADY = 1'b0;
    applyRead(12'h030, 0, 0, got);
    checkOutput("coll_new", 64'(got), 64'(32'h2));

    // Out-of-range word index 256.
    word0 = modelRead(12'h000);
    applyStimulus(12'h400, 32'hCAFEF00D, 4'hF, 0, 0, 1, 1'b1);
    applyRead(12'h400, 0, 0, got);
    applyRead(12'h000, 0, 0, got);
    checkOutput("oor_word0", 64'(got), ERR_EN ? 64'(word0) : 64'(32'hCAFEF00D));

    // Randomized traffic, mostly in range with some out-of-range addresses.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) addr = 12'($urandom_range(0, 4095));
      else                           addr = 12'($urandom_range(0, DEPTH * STRB_W - 1));
      if ($urandom_range(0, 1) == 0) begin
        applyStimulus(addr, $urandom, 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b1);
      end else begin
        applyRead(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), got);
      end
    end

    // Reset while a write response and a read response are both pending.
    rst_data = $urandom;
    checkOutput("rst_ready", 64'({AXI_AWREADY, AXI_WREADY, AXI_ARREADY}), 64'(3'b111));
    old_val = modelRead(12'h044);
    AXI_AWADDR = 12'h044; AXI_AWVALID = 1'b1;
    AXI_WDATA = rst_data; AXI_WSTRB = 4'hF; AXI_WVALID = 1'b1;
    AXI_ARADDR = 12'h044; AXI_ARVALID = 1'b1;
    stepCycle();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; AXI_ARVALID = 1'b0;
    pulse = modelWrite(12'h044, rst_data, 4'hF);
    checkOutput("rst_pre_bvalid", 64'(AXI_BVALID), 64'(1));
    checkOutput("rst_pre_rvalid", 64'(AXI_RVALID), 64'(1));
    checkOutput("rst_pre_rdata", 64'(AXI_RDATA), 64'(old_val));
    stepCycle();
    AXI_ARESET = 1'b1; AXI_BREADY = 1'b1; AXI_RREADY = 1'b1;
    stepCycle();
    checkAllZero("rst_busy");
    AXI_ARESET = 1'b0; AXI_BREADY = 1'b0; AXI_RREADY = 1'b0;
    stepCycle();
    applyRead(12'h044, 0, 0, got);
    checkOutput("rst_mem_kept", 64'(got), 64'(rst_data));
    applyStimulus(12'h048, 32'h5A5A5A5A, 4'b1001, 1, 0, 0, 1'b1);
    applyRead(12'h048, 0, 0, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a hang anywhere in the sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
